// File: rtl/fetch_packer.sv
// Fetch-side producer for the instruction buffer: issues aligned 16-byte I-cache
// requests one at a time and pushes each returned line as up to four {instr,pc} slots.
module fetch_packer #(
    parameter int          IB_WIDTH      = 16,
    parameter int          IB_WIDTH_LOG2 = 4,
    parameter int          IB_DW         = 64,
    parameter logic [31:0] RESET_PC      = 32'h1c000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic                       req_valid,
    output logic [31:0]                req_pc,
    input  logic                       req_ready,
    input  logic                       resp_valid,
    input  logic [127:0]               resp_data,
    input  logic [IB_WIDTH_LOG2:0]     if_bf_sz,
    output logic [4*IB_DW-1:0]         if1_to_ib,
    output logic [2:0]                 push_num
);

    localparam int                 FW       = IB_WIDTH_LOG2 + 1;
    localparam logic [FW-1:0]      LP_DEPTH = FW'(IB_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH,
        S_DROP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_pc;
    logic [31:0]            w_pc_nxt;
    logic [4*IB_DW-1:0]     r_pkt;
    logic [4*IB_DW-1:0]     w_pkt_nxt;
    logic [2:0]             r_n;
    logic [2:0]             w_n_nxt;
    logic [FW-1:0]          w_free;
    logic                   w_fits;
    logic                   w_req_valid;
    logic [2:0]             w_push_num;
    logic [31:0]            w_line_pc;

    // Slots beyond the end of the line stay zero; slot 0 is the word at pc.
    function automatic logic [4*IB_DW-1:0] build_pkt(input logic [31:0] pc,
                                                    input logic [127:0] line);
        logic [4*IB_DW-1:0] pkt;
        logic [1:0]         widx;
        pkt = '0;
        for (int k = 0; k < 4; k++) begin
            widx = pc[3:2] + k[1:0];
            if (k < 4 - int'(pc[3:2]))
                pkt[k*IB_DW +: IB_DW] = IB_DW'({line[widx*32 +: 32], pc + 32'(4*k)});
        end
        return pkt;
    endfunction

    function automatic logic [2:0] pkt_len(input logic [31:0] pc);
        return 3'd4 - {1'b0, pc[3:2]};
    endfunction

    assign w_line_pc = {r_pc[31:4], 4'b0000};
    // Occupancy is taken as-is; a pop in the same cycle is not credited.
    assign w_free    = LP_DEPTH - if_bf_sz;
    assign w_fits    = (w_free >= FW'(r_n));

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pkt_nxt   = r_pkt;
        w_n_nxt     = r_n;
        w_req_valid = 1'b0;
        w_push_num  = 3'd0;

        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                w_req_valid = 1'b1;
                if (req_ready)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (resp_valid) begin
                    w_pkt_nxt   = build_pkt(r_pc, resp_data);
                    w_n_nxt     = pkt_len(r_pc);
                    w_state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                if (w_fits) begin
                    w_push_num  = r_n;
                    w_pc_nxt    = w_line_pc + 32'd16;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (resp_valid)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A request already accepted, or one still in flight, must have its
        // response absorbed in DROP before the redirected fetch goes out.
        if (flush) begin
            w_push_num = 3'd0;
            w_pc_nxt   = flush_pc;
            w_pkt_nxt  = '0;
            w_n_nxt    = 3'd0;
            case (r_state)
                S_REQ:   w_state_nxt = req_ready  ? S_DROP : S_REQ;
                S_WAIT:  w_state_nxt = resp_valid ? S_REQ  : S_DROP;
                S_DROP:  w_state_nxt = resp_valid ? S_REQ  : S_DROP;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_pkt   <= '0;
            r_n     <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pkt   <= w_pkt_nxt;
            r_n     <= w_n_nxt;
        end
    end

    assign req_valid = w_req_valid & rst;
    assign req_pc    = w_line_pc;
    assign push_num  = rst ? w_push_num : 3'd0;
    assign if1_to_ib = r_pkt;

endmodule

// File: tb/tb_fetch_packer.sv
// Bench for fetch_packer: directed corner sequences, a table of alignment and
// occupancy cases, then random traffic against a flag-based behavioural model.
module tb_fetch_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  flush_pc = 32'd0;
    logic         req_valid;
    logic [31:0]  req_pc;
    logic         req_ready = 1'b0;
    logic         resp_valid = 1'b0;
    logic [127:0] resp_data = '0;
    logic [4:0]   if_bf_sz = 5'd0;
    logic [255:0] if1_to_ib;
    logic [2:0]   push_num;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_packer dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .if_bf_sz(if_bf_sz),
        .if1_to_ib(if1_to_ib), .push_num(push_num)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  bf;
        logic [2:0]  exp_push;
    } vec_t;
    vec_t tbl[8];

    // Behavioural model: fetch pc plus flags for "request in flight",
    // "in-flight response is stale" and "packet waiting to be pushed".
    bit           m_started, m_out, m_stale, m_pend;
    logic [31:0]  m_pc;
    logic [255:0] m_pkt;
    int           m_n;

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_pend = 0;
        m_pc = 32'h1c000000; m_pkt = '0; m_n = 0;
    endtask

    initial begin
        logic [31:0]  line_pc;
        logic [31:0]  w0, w1, w2, w3;
        bit           e_rv;
        int           e_push;
        int           off;

        tbl[0] = '{32'h1c000100, 5'd0,  3'd4};
        tbl[1] = '{32'h1c000114, 5'd0,  3'd3};
        tbl[2] = '{32'h1c000128, 5'd14, 3'd2};
        tbl[3] = '{32'h1c00013c, 5'd15, 3'd1};
        tbl[4] = '{32'h1c000140, 5'd13, 3'd0};
        tbl[5] = '{32'h1c000158, 5'd15, 3'd0};
        tbl[6] = '{32'hfffffff8, 5'd16, 3'd0};
        tbl[7] = '{32'hfffffffc, 5'd15, 3'd1};

        // 1: reset, one IDLE cycle, then the first request
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_req_valid", 256'(req_valid), 256'(0));
            chk("rst_push_num", 256'(push_num), 256'(0));
            cyc();
        end
        rst = 1'b1;
        #1;
        chk("idle_req_valid", 256'(req_valid), 256'(0));
        chk("idle_push_num", 256'(push_num), 256'(0));
        cyc();
        chk("first_req_valid", 256'(req_valid), 256'(1));
        chk("first_req_pc", 256'(req_pc), 256'(32'h1c000000));

        // 2: full aligned line
        req_ready = 1'b1; #1; cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};
        #1;
        chk("wait_req_valid", 256'(req_valid), 256'(0));
        cyc();
        resp_valid = 1'b0; #1;
        chk("t2_push_num", 256'(push_num), 256'(4));
        chk("t2_slot0", 256'(if1_to_ib[63:0]), 256'({32'haaaa0000, 32'h1c000000}));
        chk("t2_slot3", 256'(if1_to_ib[255:192]), 256'({32'hdddd0003, 32'h1c00000c}));
        cyc();
        chk("t2_next_req_valid", 256'(req_valid), 256'(1));
        chk("t2_next_req_pc", 256'(req_pc), 256'(32'h1c000010));

        // 3: redirect into the middle of a line
        flush = 1'b1; flush_pc = 32'h1c000028; #1;
        chk("t3_flush_push", 256'(push_num), 256'(0));
        cyc();
        flush = 1'b0; #1;
        chk("t3_req_pc", 256'(req_pc), 256'(32'h1c000020));
        req_ready = 1'b1; #1; cyc();
        req_ready = 1'b0;
        w0 = 32'h0a0a0a0a; w1 = 32'h1b1b1b1b; w2 = 32'h2c2c2c2c; w3 = 32'h3d3d3d3d;
        resp_valid = 1'b1; resp_data = {w3, w2, w1, w0}; #1; cyc();
        resp_valid = 1'b0; #1;
        chk("t3_push_num", 256'(push_num), 256'(2));
        chk("t3_slot0", 256'(if1_to_ib[63:0]), 256'({w2, 32'h1c000028}));
        chk("t3_slot1", 256'(if1_to_ib[127:64]), 256'({w3, 32'h1c00002c}));
        chk("t3_slot2_zero", 256'(if1_to_ib[255:128]), 256'(0));
        cyc();
        chk("t3_next_req_pc", 256'(req_pc), 256'(32'h1c000030));

        // 4: back-pressure holds the packet until it fits
        req_ready = 1'b1; #1; cyc();
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_data = {$urandom, $urandom, $urandom, $urandom};
        if_bf_sz = 5'd14; #1; cyc();
        resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_hold_push", 256'(push_num), 256'(0));
            chk("t4_hold_req_valid", 256'(req_valid), 256'(0));
            cyc();
        end
        if_bf_sz = 5'd12; #1;
        chk("t4_release_push", 256'(push_num), 256'(4));
        cyc();
        if_bf_sz = 5'd0; #1;
        chk("t4_req_valid", 256'(req_valid), 256'(1));
        chk("t4_req_pc", 256'(req_pc), 256'(32'h1c000040));

        // 5: flush while waiting, second flush in DROP, then the stale response
        req_ready = 1'b1; #1; cyc();
        req_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c000054; #1; cyc();
        flush = 1'b0; #1;
        chk("t5_drop_req_valid", 256'(req_valid), 256'(0));
        cyc();
        chk("t5_drop_req_valid2", 256'(req_valid), 256'(0));
        flush = 1'b1; flush_pc = 32'h1c000064; #1; cyc();
        flush = 1'b0; #1;
        chk("t5_drop2_req_valid", 256'(req_valid), 256'(0));
        resp_valid = 1'b1; resp_data = {$urandom, $urandom, $urandom, $urandom}; #1;
        chk("t5_stale_push", 256'(push_num), 256'(0));
        chk("t5_stale_req_valid", 256'(req_valid), 256'(0));
        cyc();
        resp_valid = 1'b0; #1;
        chk("t5_req_valid", 256'(req_valid), 256'(1));
        chk("t5_req_pc", 256'(req_pc), 256'(32'h1c000060));

        // 6: flush coinciding with the response
        req_ready = 1'b1; #1; cyc();
        req_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h1c000070; resp_valid = 1'b1; #1;
        chk("t6_push", 256'(push_num), 256'(0));
        cyc();
        flush = 1'b0; resp_valid = 1'b0; #1;
        chk("t6_req_valid", 256'(req_valid), 256'(1));
        chk("t6_req_pc", 256'(req_pc), 256'(32'h1c000070));
        cyc();
        chk("t6_push_after", 256'(push_num), 256'(0));
        chk("t6_still_req", 256'(req_valid), 256'(1));

        // Table: alignment offsets against buffer occupancy
        foreach (tbl[i]) begin
            flush = 1'b1; flush_pc = tbl[i].pc; #1; cyc();
            flush = 1'b0; #1;
            line_pc = tbl[i].pc & 32'hfffffff0;
            chk("tbl_req_valid", 256'(req_valid), 256'(1));
            chk("tbl_req_pc", 256'(req_pc), 256'(line_pc));
            req_ready = 1'b1; #1; cyc();
            req_ready = 1'b0;
            resp_valid = 1'b1; resp_data = {$urandom, $urandom, $urandom, $urandom};
            if_bf_sz = tbl[i].bf; #1; cyc();
            resp_valid = 1'b0; #1;
            chk("tbl_push_num", 256'(push_num), 256'(tbl[i].exp_push));
            if (tbl[i].exp_push != 3'd0) begin
                off = int'(tbl[i].pc[3:2]);
                chk("tbl_slot0", 256'(if1_to_ib[63:0]), 256'({resp_data[32*off +: 32], tbl[i].pc}));
                cyc();
            end
        end
        if_bf_sz = 5'd0; #1;
        chk("wrap_req_pc", 256'(req_pc), 256'(0));

        // Reset while a request is outstanding
        req_ready = 1'b1; #1; cyc();
        req_ready = 1'b0; rst = 1'b0; #1;
        chk("midrst_req_valid", 256'(req_valid), 256'(0));
        cyc();
        rst = 1'b1; #1;
        chk("midrst_idle", 256'(req_valid), 256'(0));
        cyc();
        chk("midrst_req_pc", 256'(req_pc), 256'(32'h1c000000));
        chk("midrst_req_valid2", 256'(req_valid), 256'(1));

        // Random traffic against the model
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = (i < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            flush_pc   = $urandom & 32'hfffffffc;
            if ($urandom_range(0, 7) == 0) flush_pc = 32'hfffffff0 | (flush_pc & 32'hc);
            req_ready  = ($urandom_range(0, 2) != 0);
            resp_valid = m_out && ($urandom_range(0, 2) == 0);
            resp_data  = {$urandom, $urandom, $urandom, $urandom};
            if_bf_sz   = 5'($urandom_range(0, 16));
            #1;
            e_rv   = rst && m_started && !m_out && !m_pend;
            e_push = (rst && m_pend && !flush && (16 - int'(if_bf_sz)) >= m_n) ? m_n : 0;
            chk("rnd_req_valid", 256'(req_valid), 256'(e_rv));
            if (e_rv) chk("rnd_req_pc", 256'(req_pc), 256'(m_pc & 32'hfffffff0));
            chk("rnd_push_num", 256'(push_num), 256'(e_push));
            if (e_push != 0) chk("rnd_slots", if1_to_ib, m_pkt);

            if (!rst) begin
                model_reset();
            end else if (flush) begin
                m_pc = flush_pc;
                m_pend = 0;
                if (!m_started) m_started = 1;
                else if (e_rv && req_ready) begin m_out = 1; m_stale = 1; end
                else if (m_out) begin
                    if (resp_valid) m_out = 0;
                    else m_stale = 1;
                end
            end else if (!m_started) begin
                m_started = 1;
            end else if (e_rv) begin
                if (req_ready) begin m_out = 1; m_stale = 0; end
            end else if (m_out) begin
                if (resp_valid) begin
                    m_out = 0;
                    if (!m_stale) begin
                        off = int'((m_pc >> 2) & 32'd3);
                        m_n = 4 - off;
                        m_pkt = '0;
                        for (int k = 0; k < m_n; k++)
                            m_pkt[64*k +: 64] = {resp_data[32*(off+k) +: 32], m_pc + 32'(4*k)};
                        m_pend = 1;
                    end
                end
            end else if (m_pend && e_push != 0) begin
                m_pend = 0;
                m_pc = (m_pc & 32'hfffffff0) + 32'd16;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
